encoder_8to3_seq: RTL and testbench

- Sequential 8-to-3 priority encoder: the return path for 3-to-8 one-hot select decoding.
- Latches request bits into a sticky pending register.
- Issues the binary index of the lowest-numbered pending bit over a valid/ready handshake, then clears that bit once it is accepted.
- Sits between request sources (one-hot or multi-hot) and any consumer that needs a 3-bit index stream.

---
 rtl/enc_pkg.sv | 14 +
 rtl/prio_lsb_enc.sv | 24 ++
 rtl/encoder_8to3_seq.sv | 76 +++++++
 tb/tb_encoder_8to3_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Purpose: shared constants and FSM state type for the sequential priority encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enc_pkg;

    localparam int ENC_N_IN  = 8;
    localparam int ENC_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } enc_state_t;

endpackage

// File: rtl/prio_lsb_enc.sv
// Purpose: combinational lowest-set-bit encoder with a nonzero flag (bit 0 wins).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows input.
module prio_lsb_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         nz
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        nz  = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/encoder_8to3_seq.sv
// Purpose: sticky request register drained lowest-index first as a 3-bit index stream.
// Latency: 2 cycles from d to valid (capture edge, then grant edge); one grant per 2 cycles peak.
// Backpressure: y/valid held stable while ready=0; no pre-emption by newer higher-priority bits.
module encoder_8to3_seq
    import enc_pkg::*;
#(
    parameter int N_IN  = ENC_N_IN,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_IN-1:0]  d,
    output logic [IDX_W-1:0] y,
    output logic             valid,
    input  logic             ready,
    output logic [N_IN-1:0]  pending,
    output logic             busy
);

    enc_state_t       state;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_nz;
    logic             accept;
    logic [N_IN-1:0]  clr_mask;
    logic [N_IN-1:0]  set_mask;

    // Selection looks only at the registered pending bits, never at same-cycle d.
    prio_lsb_enc #(
        .N (N_IN),
        .W (IDX_W)
    ) u_prio (
        .req (pending),
        .idx (sel_idx),
        .nz  (sel_nz)
    );

    assign accept   = (state == GRANT) && ready;
    assign clr_mask = accept ? ({{(N_IN-1){1'b0}}, 1'b1} << y) : '0;
    assign set_mask = en ? d : '0;
    assign busy     = (|pending) || valid;

    // Pending register plus grant FSM; set is ORed in after clear so a re-request survives accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            y       <= '0;
            valid   <= 1'b0;
            state   <= IDLE;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            case (state)
                IDLE: begin
                    if (sel_nz) begin
                        y     <= sel_idx;
                        valid <= 1'b1;
                        state <= GRANT;
                    end else begin
                        valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (ready) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8to3_seq.sv
module tb_encoder_8to3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic [2:0] y;
    logic       valid;
    logic       ready;
    logic [7:0] pending;
    logic       busy;

    int checks = 0;
    int errors = 0;

    encoder_8to3_seq dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .d       (d),
        .y       (y),
        .valid   (valid),
        .ready   (ready),
        .pending (pending),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; d = 8'hFF; ready = 1'b1;
        tick();
        tick();
        checks++;
        if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h exp 00", pending); end
        checks++;
        if (valid !== 1'b0 || y !== 3'd0) begin errors++; $display("FAIL reset_out got valid=%b y=%0d exp valid=0 y=0", valid, y); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0; en = 1'b0; d = 8'h00; ready = 1'b0;
        tick();
    endtask

    task automatic test_single();
        ready = 1'b1;
        en = 1'b1; d = 8'b0000_0100;
        tick();
        en = 1'b0; d = 8'h00;
        checks++;
        if (pending !== 8'h04 || valid !== 1'b0) begin errors++; $display("FAIL single_capture got pending=%h valid=%b exp 04 0", pending, valid); end
        tick();
        checks++;
        if (valid !== 1'b1 || y !== 3'b010) begin errors++; $display("FAIL single_grant got valid=%b y=%0d exp 1 2", valid, y); end
        tick();
        checks++;
        if (pending !== 8'h00 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_drain got pending=%h valid=%b busy=%b exp 00 0 0", pending, valid, busy);
        end
        ready = 1'b0;
    endtask

    task automatic test_priority();
        logic [2:0] exp_y  [3] = '{3'd1, 3'd4, 3'd7};
        logic [7:0] exp_pg [3] = '{8'h92, 8'h90, 8'h80};
        logic [7:0] exp_pa [3] = '{8'h90, 8'h80, 8'h00};
        ready = 1'b1;
        en = 1'b1; d = 8'b1001_0010;
        tick();
        en = 1'b0; d = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || y !== exp_y[k] || pending !== exp_pg[k]) begin
                errors++; $display("FAIL prio_grant%0d got valid=%b y=%0d pending=%h exp 1 %0d %h", k, valid, y, pending, exp_y[k], exp_pg[k]);
            end
            tick();
            checks++;
            if (valid !== 1'b0 || pending !== exp_pa[k]) begin
                errors++; $display("FAIL prio_gap%0d got valid=%b pending=%h exp 0 %h", k, valid, pending, exp_pa[k]);
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        en = 1'b1; d = 8'h80;
        tick();
        en = 1'b0; d = 8'h00;
        tick();
        checks++;
        if (valid !== 1'b1 || y !== 3'd7) begin errors++; $display("FAIL bp_grant got valid=%b y=%0d exp 1 7", valid, y); end
        en = 1'b1; d = 8'h01;
        tick();
        en = 1'b0; d = 8'h00;
        tick();
        checks++;
        if (valid !== 1'b1 || y !== 3'd7 || pending !== 8'h81) begin
            errors++; $display("FAIL bp_hold got valid=%b y=%0d pending=%h exp 1 7 81", valid, y, pending);
        end
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 8'h01) begin errors++; $display("FAIL bp_accept got valid=%b pending=%h exp 0 01", valid, pending); end
        tick();
        checks++;
        if (valid !== 1'b1 || y !== 3'd0) begin errors++; $display("FAIL bp_next got valid=%b y=%0d exp 1 0", valid, y); end
        tick();
        checks++;
        if (pending !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain got pending=%h busy=%b exp 00 0", pending, busy); end
        ready = 1'b0;
    endtask

    task automatic test_set_wins();
        ready = 1'b0;
        en = 1'b1; d = 8'h08;
        tick();
        en = 1'b0; d = 8'h00;
        tick();
        checks++;
        if (valid !== 1'b1 || y !== 3'd3) begin errors++; $display("FAIL sw_grant got valid=%b y=%0d exp 1 3", valid, y); end
        ready = 1'b1; en = 1'b1; d = 8'h08;
        tick();
        en = 1'b0; d = 8'h00;
        checks++;
        if (valid !== 1'b0 || pending !== 8'h08) begin errors++; $display("FAIL sw_keep got valid=%b pending=%h exp 0 08", valid, pending); end
        tick();
        checks++;
        if (valid !== 1'b1 || y !== 3'd3) begin errors++; $display("FAIL sw_regrant got valid=%b y=%0d exp 1 3", valid, y); end
        tick();
        checks++;
        if (pending !== 8'h00 || valid !== 1'b0) begin errors++; $display("FAIL sw_drain got pending=%h valid=%b exp 00 0", pending, valid); end
        ready = 1'b0;
    endtask

    task automatic test_enable();
        ready = 1'b1;
        en = 1'b0; d = 8'hFF;
        tick();
        tick();
        checks++;
        if (pending !== 8'h00 || valid !== 1'b0) begin errors++; $display("FAIL en_gate got pending=%h valid=%b exp 00 0", pending, valid); end
        en = 1'b1; d = 8'h05;
        tick();
        en = 1'b0; d = 8'hFF;
        tick();
        checks++;
        if (valid !== 1'b1 || y !== 3'd0) begin errors++; $display("FAIL en_drain0 got valid=%b y=%0d exp 1 0", valid, y); end
        tick();
        checks++;
        if (pending !== 8'h04) begin errors++; $display("FAIL en_mid got pending=%h exp 04", pending); end
        tick();
        checks++;
        if (valid !== 1'b1 || y !== 3'd2) begin errors++; $display("FAIL en_drain1 got valid=%b y=%0d exp 1 2", valid, y); end
        tick();
        checks++;
        if (pending !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL en_empty got pending=%h busy=%b exp 00 0", pending, busy); end
        d = 8'h00; ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        en = 1'b1; d = 8'h3C;
        tick();
        en = 1'b0; d = 8'h00;
        tick();
        checks++;
        if (valid !== 1'b1 || y !== 3'd2 || pending !== 8'h3C) begin
            errors++; $display("FAIL rm_pre got valid=%b y=%0d pending=%h exp 1 2 3C", valid, y, pending);
        end
        rst = 1'b1; ready = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (valid !== 1'b0 || y !== 3'd0 || pending !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL rm_post got valid=%b y=%0d pending=%h busy=%b exp 0 0 00 0", valid, y, pending, busy);
        end
        tick();
        tick();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_quiet got valid=%b busy=%b exp 0 0", valid, busy); end
        ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; d = 8'h00; ready = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_set_wins();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
